// File: rtl/rgb2ycbcr_pkg.sv
// Shared constants and FSM state type for the RGB -> YCbCr block converter.
// Coefficients are the 8-bit fixed-point BT.601 set, scaled by 256.
package rgb2ycbcr_pkg;
  localparam int C_YR  = 77;
  localparam int C_YG  = 150;
  localparam int C_YB  = 29;
  localparam int C_CBR = 43;
  localparam int C_CBG = 85;
  localparam int C_CBB = 128;
  localparam int C_CRR = 128;
  localparam int C_CRG = 107;
  localparam int C_CRB = 21;

  localparam int OFFSET_C  = 32768;
  localparam int LEVEL_OFF = 32768;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/rgb2ycbcr_lane.sv
// One-pixel converter: stage 1 registers the nine products, stage 2 sums
// them combinationally so the parent can land the result in its output register.
module rgb2ycbcr_lane
  import rgb2ycbcr_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] r_i,
  input  logic [PIX_W-1:0] g_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic             valid_i,
  input  logic             level_shift_i,
  output logic [OUT_W-1:0] y_o,
  output logic [OUT_W-1:0] cb_o,
  output logic [OUT_W-1:0] cr_o,
  output logic             valid_o
);
  localparam int PW = PIX_W + 8;

  logic [PW-1:0] yr_q, yg_q, yb_q, cbr_q, cbg_q, cbb_q, crr_q, crg_q, crb_q;
  logic          vld_q, ls_q;
  int            y_s, cb_s, cr_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      vld_q <= valid_i;
      ls_q  <= level_shift_i;
    end
  end

  always_ff @(posedge clk) begin
    if (valid_i) begin
      yr_q  <= PW'(C_YR  * int'(r_i));
      yg_q  <= PW'(C_YG  * int'(g_i));
      yb_q  <= PW'(C_YB  * int'(b_i));
      cbr_q <= PW'(C_CBR * int'(r_i));
      cbg_q <= PW'(C_CBG * int'(g_i));
      cbb_q <= PW'(C_CBB * int'(b_i));
      crr_q <= PW'(C_CRR * int'(r_i));
      crg_q <= PW'(C_CRG * int'(g_i));
      crb_q <= PW'(C_CRB * int'(b_i));
    end
  end

  // Signed 32-bit sums; every result lands in 0..65408 before the optional shift.
  always_comb begin
    y_s  = int'(yr_q) + int'(yg_q) + int'(yb_q);
    cb_s = OFFSET_C - int'(cbr_q) - int'(cbg_q) + int'(cbb_q);
    cr_s = OFFSET_C + int'(crr_q) - int'(crg_q) - int'(crb_q);
    if (ls_q) begin
      y_s  = y_s  - LEVEL_OFF;
      cb_s = cb_s - LEVEL_OFF;
      cr_s = cr_s - LEVEL_OFF;
    end
  end

  assign y_o     = OUT_W'(y_s);
  assign cb_o    = OUT_W'(cb_s);
  assign cr_o    = OUT_W'(cr_s);
  assign valid_o = vld_q;
endmodule

// File: rtl/rgb2ycbcr_block.sv
// Block-level RGB -> YCbCr converter: captures a block on start, streams it
// through LANES converters one group per cycle and holds the planes when done.
module rgb2ycbcr_block
  import rgb2ycbcr_pkg::*;
#(
  parameter int PIXELS = 64,
  parameter int LANES  = 8,
  parameter int PIX_W  = 8,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    level_shift,
  input  logic [PIXELS*PIX_W-1:0] R,
  input  logic [PIXELS*PIX_W-1:0] G,
  input  logic [PIXELS*PIX_W-1:0] B,
  output logic [PIXELS*OUT_W-1:0] Y_out,
  output logic [PIXELS*OUT_W-1:0] Cb_out,
  output logic [PIXELS*OUT_W-1:0] Cr_out,
  output logic                    busy,
  output logic                    finished
);
  localparam int N  = PIXELS / LANES;
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam logic [GW-1:0] LAST = GW'(N - 1);

  if (LANES < 1 || PIXELS % LANES != 0) begin : g_bad_cfg
    $error("rgb2ycbcr_block: PIXELS must be a positive multiple of LANES");
  end

  state_e                          state_q, state_d;
  logic [PIXELS*PIX_W-1:0]         r_q, g_q, b_q;
  logic                            ls_q;
  logic [GW-1:0]                   grp_q, s1_grp_q;
  logic                            issued_q;
  logic                            accept, issue, s1_vld;
  logic [LANES-1:0]                lane_vld;
  logic [LANES-1:0][OUT_W-1:0]     y_l, cb_l, cr_l;
  logic [PIXELS*OUT_W-1:0]         y_q, cb_q, cr_q;

  assign accept = start && (state_q != RUN);
  assign issue  = (state_q == RUN) && !issued_q;
  assign s1_vld = &lane_vld;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (s1_vld && s1_grp_q == LAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      r_q <= R;
      g_q <= G;
      b_q <= B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ls_q     <= 1'b0;
      grp_q    <= '0;
      s1_grp_q <= '0;
      issued_q <= 1'b0;
      y_q      <= '0;
      cb_q     <= '0;
      cr_q     <= '0;
    end else begin
      state_q  <= state_d;
      s1_grp_q <= grp_q;
      if (accept) begin
        ls_q     <= level_shift;
        grp_q    <= '0;
        issued_q <= 1'b0;
      end else if (issue) begin
        if (grp_q == LAST) issued_q <= 1'b1;
        else               grp_q    <= grp_q + GW'(1);
      end
      // Stage-2 results of the group issued two edges ago land in place.
      if (s1_vld) begin
        for (int l = 0; l < LANES; l++) begin
          y_q [(int'(s1_grp_q)*LANES + l)*OUT_W +: OUT_W] <= y_l[l];
          cb_q[(int'(s1_grp_q)*LANES + l)*OUT_W +: OUT_W] <= cb_l[l];
          cr_q[(int'(s1_grp_q)*LANES + l)*OUT_W +: OUT_W] <= cr_l[l];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    rgb2ycbcr_lane #(.PIX_W(PIX_W), .OUT_W(OUT_W)) u_lane (
      .clk           (clk),
      .rst           (rst),
      .r_i           (r_q[(int'(grp_q)*LANES + l)*PIX_W +: PIX_W]),
      .g_i           (g_q[(int'(grp_q)*LANES + l)*PIX_W +: PIX_W]),
      .b_i           (b_q[(int'(grp_q)*LANES + l)*PIX_W +: PIX_W]),
      .valid_i       (issue),
      .level_shift_i (ls_q),
      .y_o           (y_l[l]),
      .cb_o          (cb_l[l]),
      .cr_o          (cr_l[l]),
      .valid_o       (lane_vld[l])
    );
  end

  assign Y_out    = y_q;
  assign Cb_out   = cb_q;
  assign Cr_out   = cr_q;
  assign busy     = (state_q == RUN);
  assign finished = (state_q == DONE);
endmodule

// File: doc/rgb2ycbcr_block.md
# rgb2ycbcr_block

Parametrised successor of the 8x8 RGB-to-luma wrapper. It accepts one block of PIXELS RGB pixels on flat buses with a start pulse and processes LANES pixels per cycle through a 2-stage fixed-point pipeline. It produces Y, Cb and Cr planes in Q8.8, with an optional DCT level shift, and holds `finished` until the next block is accepted. It sits between the block loader and the DCT/quantisation stage.

## Interface
Parameters:
- PIXELS, 64: pixels per block; must be a multiple of LANES, otherwise elaboration error.
- LANES, 8: pixels converted per cycle (1..PIXELS).
- PIX_W, 8: input component width; the coefficient set is fixed for 8.
- OUT_W, 16: output component width, Q8.8.

Ports (reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to process the block on R/G/B.
- level_shift  in  1  sampled with start; 1 = signed outputs centred on 0.
- R, G, B  in  PIXELS*PIX_W each  pixel i at [i*PIX_W +: PIX_W].
- Y_out, Cb_out, Cr_out  out  PIXELS*OUT_W each  pixel i at [i*OUT_W +: OUT_W].
- busy  out  1  block in progress.
- finished  out  1  block complete; outputs valid.

## Operation
- FSM states are IDLE, RUN, DONE.
  - IDLE/DONE with start=1: capture R, G, B and level_shift into internal registers, clear finished, go to RUN, set busy.
  - RUN: issue lane group k = 0..N-1 (N = PIXELS/LANES), one group per cycle, pixels k*LANES .. k*LANES+LANES-1.
  - After the last group writes back: go to DONE, finished=1, busy=0.
  - DONE: finished and outputs stay held until the next accepted start.
- start while in RUN is ignored; it is not queued.
- Input buses may change freely after the accept edge.
- Arithmetic is per pixel, unsigned 8-bit components, exact integer, no rounding:
  - Y  = 77R + 150G + 29B.
  - Cb = 32768 − 43R − 85G + 128B.
  - Cr = 32768 + 128R − 107G − 21B.
  - Intermediates are at least 18 bits signed.
  - Results lie in 0..65408, so they fit in 16 bits unsigned with no saturation needed.
- level_shift=1: subtract 32768 from each result and output as 16-bit two's complement.
- Output pixels not yet written in the current block keep their previous values.

## Timing
- Accept edge E0: inputs captured.
- Group k:
  - enters stage 1 (products registered) at edge E(k+1);
  - reaches stage 2 (sum + offset, written to the output register) at edge E(k+2).
- finished rises at edge E(N+1), the same edge as the last write. Start-to-finished latency is N+1 cycles; 9 for the defaults.
- busy is high from E0 through E(N+1), exclusive.
- Back-to-back: start may be asserted in the cycle finished first rises. Its accept edge lowers finished. Throughput is N+1 cycles per block.
- Reset values: all outputs 0, busy 0, finished 0, FSM IDLE, pipeline valid bits 0.
- rst has priority over start. Reset mid-RUN aborts the block; no finished pulse follows.

## Structure
- Package `rgb2ycbcr_pkg` contains:
  - coefficient localparams (77, 150, 29, 43, 85, 128, 107, 21);
  - OFFSET_C = 32768 and LEVEL_OFF = 32768;
  - state enum {IDLE, RUN, DONE}.
- Sub-module `rgb2ycbcr_lane`: one-pixel, 2-stage pipeline with inputs r, g, b, valid, level_shift and outputs y, cb, cr, valid. It is instantiated LANES times.
- The top holds the FSM, the group counter (clog2(N) bits, minimum 1), input capture registers and output registers.

## Test plan
- Black block, level_shift=0 → every Y=0x0000, Cb=Cr=0x8000; finished observed exactly 9 cycles after the accept edge.
- White (255,255,255) block, level_shift=1 → Y=0x7F00, Cb=Cr=0x0000; pure-red block, level_shift=0 → Y=0x4CB3, Cb=0x552B, Cr=0xFF80.
- Ramp block (pixel i: R=i, G=2i, B=255−i) compared against a bench reference model, run with LANES=1, 8 and 64 → latency 65, 9 and 2 cycles respectively.
- Second start pulsed in cycle 3 of RUN → ignored, outputs match the first block. Start asserted in the cycle finished first rises → accepted, second block finished 9 cycles later.
- rst asserted in cycle 4 of RUN → next edge: all outputs 0, busy=0, finished=0. A subsequent start completes normally.
- 1000 random blocks with random level_shift versus the reference model → zero mismatches, no timeouts.
